// File: rtl/vend_pkg.sv
// Shared FSM state encoding for the vending controller and its stock tracker.
// Pure types/constants: no latency or flow-control of its own.
package vend_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'b00,
        CREDIT   = 2'b01,
        DISPENSE = 2'b10,
        CHANGE   = 2'b11
    } state_t;

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counters, loaded at reset, one saturating decrement per cycle.
// sold_out is registered and reflects a decrement in the cycle after it; no backpressure.
module vend_stock
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 2,
    parameter int INIT_STOCK = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec,
    input  logic [SEL_W-1:0]     dec_sel,
    output logic [NUM_ITEMS-1:0] sold_out
);

    logic [STOCK_W-1:0] stock     [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_nxt [NUM_ITEMS];

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_nxt[i] = stock[i];
            if (dec && dec_sel == SEL_W'(i) && stock[i] != '0)
                stock_nxt[i] = stock[i] - 1'b1;
        end
    end

    // sold_out is taken from the next-state value so it stays in step with stock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i]    <= STOCK_W'(INIT_STOCK);
                sold_out[i] <= (INIT_STOCK == 0);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock[i]    <= stock_nxt[i];
                sold_out[i] <= (stock_nxt[i] == '0);
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Multi-item vending FSM: coin credit, purchase, change; candy one cycle after the buy edge, change one after that.
// No backpressure: refused coins pulse coin_reject next cycle; VEND_TIMEOUT_EN adds an inactivity refund in CREDIT.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int COIN_W     = 2,
    parameter int CREDIT_W   = 4,
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 2,
    parameter int INIT_STOCK = 2
`ifdef VEND_TIMEOUT_EN
    , parameter int TIMEOUT  = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [COIN_W-1:0]    coin_value,
    input  logic                 button,
    input  logic [SEL_W-1:0]     sel,
    output logic [STATE_W-1:0]   state,
    output logic                 candy,
    output logic [SEL_W-1:0]     item,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 coin_reject,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0] PRICE_S    = SUM_W'(PRICE);

    state_t               state_q;
    logic                 busy;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     eff;
    logic                 coin_ok;
    logic                 buy_ok;
    logic                 reject_nxt;
    logic                 tmo_hit;
    logic [(1<<SEL_W)-1:0] avail;

    assign state = state_q;
    assign busy  = (state_q == DISPENSE) || (state_q == CHANGE);
    assign sum   = {1'b0, credit} + SUM_W'(coin_value);

    assign coin_ok    = !busy && coin_valid && coin_value != '0 && sum <= CREDIT_MAX;
    assign eff        = coin_ok ? sum : {1'b0, credit};
    assign reject_nxt = coin_valid && (busy || (coin_value != '0 && !coin_ok));

    // Selections beyond NUM_ITEMS land on zero bits and can never buy
    always_comb begin
        avail                = '0;
        avail[NUM_ITEMS-1:0] = ~sold_out;
    end

    assign buy_ok = !busy && button && avail[sel] && eff >= PRICE_S;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] idle_cnt;

    assign tmo_hit = (state_q == CREDIT) && !coin_valid && !button &&
                     idle_cnt == TMO_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (state_q != CREDIT || coin_valid || button || tmo_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            credit       <= '0;
            candy        <= 1'b0;
            item         <= '0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
        end else begin
            coin_reject  <= reject_nxt;
            candy        <= 1'b0;
            change_valid <= 1'b0;
            change       <= '0;
            case (state_q)
                IDLE, CREDIT: begin
                    if (buy_ok) begin
                        state_q <= DISPENSE;
                        credit  <= CREDIT_W'(eff - PRICE_S);
                        item    <= sel;
                        candy   <= 1'b1;
                    end else if (coin_ok) begin
                        state_q <= CREDIT;
                        credit  <= eff[CREDIT_W-1:0];
                    end else if (tmo_hit) begin
                        state_q      <= CHANGE;
                        change_valid <= 1'b1;
                        change       <= credit;
                    end
                end
                DISPENSE: begin
                    if (credit != '0) begin
                        state_q      <= CHANGE;
                        change_valid <= 1'b1;
                        change       <= credit;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHANGE: begin
                    credit  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    vend_stock #(
        .NUM_ITEMS  (NUM_ITEMS),
        .SEL_W      (SEL_W),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .reset    (reset),
        .dec      (buy_ok),
        .dec_sel  (sel),
        .sold_out (sold_out)
    );

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural vending model.
module tb_vend_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_value = 2'b00;
    logic       button = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [1:0] state;
    logic       candy;
    logic [1:0] item;
    logic       change_valid;
    logic [3:0] change;
    logic [3:0] credit;
    logic       coin_reject;
    logic [3:0] sold_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 holding credit, 2 dispensing, 3 paying change
    int m_state, m_credit, m_item, m_change, m_rej, m_idle;
    int m_stock [4];

    vend_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .button       (button),
        .sel          (sel),
        .state        (state),
        .candy        (candy),
        .item         (item),
        .change_valid (change_valid),
        .change       (change),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .sold_out     (sold_out)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] pack(int st, int cd, int it, int cv, int chg, int cr, int rej, int so);
        return {2'(st), 1'(cd), 2'(it), 1'(cv), 4'(chg), 4'(cr), 1'(rej), 4'(so)};
    endfunction

    function automatic logic [18:0] obs();
        return {state, candy, candy ? item : 2'b00, change_valid, change, credit, coin_reject, sold_out};
    endfunction

    function automatic logic [18:0] model_exp();
        int so = 0;
        for (int i = 0; i < 4; i++)
            if (m_stock[i] == 0) so += (1 << i);
        return pack(m_state, (m_state == 2) ? 1 : 0, (m_state == 2) ? m_item : 0,
                    (m_state == 3) ? 1 : 0, m_change, m_credit, m_rej, so);
    endfunction

    task automatic model_reset();
        m_state = 0; m_credit = 0; m_item = 0; m_change = 0; m_rej = 0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 2;
    endtask

    task automatic model_step(input int cv, input int val, input int btn, input int s);
        int prev;
        int busy;
        int acc;
        int eff;
        int buy;
        prev = m_state;
        busy = (m_state >= 2) ? 1 : 0;
        acc  = (!busy && cv != 0 && val != 0 && m_credit + val <= 15) ? 1 : 0;
        eff  = m_credit + (acc ? val : 0);
        buy  = (!busy && btn != 0 && s < 4 && m_stock[s] > 0 && eff >= 3) ? 1 : 0;
        m_rej = (cv != 0 && (busy || (val != 0 && !acc))) ? 1 : 0;
        m_change = 0;
        if (m_state == 2) begin
            if (m_credit > 0) begin m_state = 3; m_change = m_credit; end
            else m_state = 0;
        end else if (m_state == 3) begin
            m_credit = 0; m_state = 0;
        end else if (buy) begin
            m_stock[s] -= 1; m_credit = eff - 3; m_item = s; m_state = 2;
        end else if (acc) begin
            m_credit = eff; m_state = 1;
        end else if (m_state == 1 && cv == 0 && btn == 0) begin
`ifdef VEND_TIMEOUT_EN
            if (m_idle == TIMEOUT - 1) begin m_state = 3; m_change = m_credit; end
`endif
        end
        if (prev == 1 && m_state == 1 && cv == 0 && btn == 0) m_idle++;
        else m_idle = 0;
    endtask

    task automatic step(input int cv, input int val, input int btn, input int s);
        coin_valid = 1'(cv); coin_value = 2'(val); button = 1'(btn); sel = 2'(s);
        @(posedge clk);
        model_step(cv, val, btn, s);
        @(negedge clk);
        coin_valid = 1'b0; coin_value = 2'b00; button = 1'b0; sel = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (obs() !== pack(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1, 3, 1, 0);
        n_tests++;
        if (obs() !== pack(2, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_prebuy: got %h expected %h", obs(), pack(2, 1, 0, 0, 0, 0, 0, 0));
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (obs() !== pack(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++; $display("FAIL reset_mid_dispense: got %h expected %h", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_buy();
        int stim [4][4] = '{'{1, 1, 0, 0}, '{1, 2, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 0}};
        logic [18:0] expv [4];
        expv = '{pack(1, 0, 0, 0, 0, 1, 0, 0), pack(1, 0, 0, 0, 0, 3, 0, 0),
                 pack(2, 1, 0, 0, 0, 0, 0, 0), pack(0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            step(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            n_tests++;
            if (obs() !== expv[i]) begin
                n_fail++; $display("FAIL basic_buy[%0d]: got %h expected %h", i, obs(), expv[i]);
            end
        end
    endtask

    task automatic test_change();
        int stim [5][4] = '{'{1, 3, 0, 0}, '{1, 3, 0, 0}, '{0, 0, 1, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        logic [18:0] expv [5];
        expv = '{pack(1, 0, 0, 0, 0, 3, 0, 0), pack(1, 0, 0, 0, 0, 6, 0, 0),
                 pack(2, 1, 2, 0, 0, 3, 0, 0), pack(3, 0, 0, 1, 3, 3, 0, 0),
                 pack(0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            step(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            n_tests++;
            if (obs() !== expv[i]) begin
                n_fail++; $display("FAIL change[%0d]: got %h expected %h", i, obs(), expv[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        int stim [2][4] = '{'{1, 3, 1, 1}, '{0, 0, 0, 0}};
        logic [18:0] expv [2];
        expv = '{pack(2, 1, 1, 0, 0, 0, 0, 0), pack(0, 0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 2; i++) begin
            step(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            n_tests++;
            if (obs() !== expv[i]) begin
                n_fail++; $display("FAIL same_cycle[%0d]: got %h expected %h", i, obs(), expv[i]);
            end
        end
    endtask

    task automatic test_sold_out();
        int stim [8][4] = '{'{1, 3, 1, 3}, '{0, 0, 0, 0}, '{1, 3, 1, 3}, '{0, 0, 0, 0},
                            '{1, 3, 0, 0}, '{0, 0, 1, 3}, '{0, 0, 1, 1}, '{0, 0, 0, 0}};
        logic [18:0] expv [8];
        expv = '{pack(2, 1, 3, 0, 0, 0, 0, 0), pack(0, 0, 0, 0, 0, 0, 0, 0),
                 pack(2, 1, 3, 0, 0, 0, 0, 8), pack(0, 0, 0, 0, 0, 0, 0, 8),
                 pack(1, 0, 0, 0, 0, 3, 0, 8), pack(1, 0, 0, 0, 0, 3, 0, 8),
                 pack(2, 1, 1, 0, 0, 0, 0, 10), pack(0, 0, 0, 0, 0, 0, 0, 10)};
        for (int i = 0; i < 8; i++) begin
            step(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            n_tests++;
            if (obs() !== expv[i]) begin
                n_fail++; $display("FAIL sold_out[%0d]: got %h expected %h", i, obs(), expv[i]);
            end
        end
    endtask

    task automatic test_reject();
        int stim [10][4] = '{'{1, 3, 0, 0}, '{1, 3, 0, 0}, '{1, 3, 0, 0}, '{1, 3, 0, 0}, '{1, 2, 0, 0},
                             '{1, 3, 0, 0}, '{0, 0, 1, 2}, '{1, 1, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        logic [18:0] expv [10];
        expv = '{pack(1, 0, 0, 0, 0, 3, 0, 10), pack(1, 0, 0, 0, 0, 6, 0, 10),
                 pack(1, 0, 0, 0, 0, 9, 0, 10), pack(1, 0, 0, 0, 0, 12, 0, 10),
                 pack(1, 0, 0, 0, 0, 14, 0, 10), pack(1, 0, 0, 0, 0, 14, 1, 10),
                 pack(2, 1, 2, 0, 0, 11, 0, 14), pack(3, 0, 0, 1, 11, 11, 1, 14),
                 pack(0, 0, 0, 0, 0, 0, 0, 14), pack(0, 0, 0, 0, 0, 0, 0, 14)};
        for (int i = 0; i < 10; i++) begin
            step(stim[i][0], stim[i][1], stim[i][2], stim[i][3]);
            n_tests++;
            if (obs() !== expv[i]) begin
                n_fail++; $display("FAIL reject[%0d]: got %h expected %h", i, obs(), expv[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int hit_k = 0;
        int hit_chg = 0;
        step(1, 2, 0, 0);
        for (int k = 1; k <= TIMEOUT + 4; k++) begin
            step(0, 0, 0, 0);
            if (change_valid === 1'b1 && hit_k == 0) begin hit_k = k; hit_chg = int'(change); end
        end
`ifdef VEND_TIMEOUT_EN
        n_tests++;
        if (hit_k != TIMEOUT || hit_chg != 2) begin
            n_fail++; $display("FAIL timeout_refund: got cycle %0d change %0d expected cycle %0d change 2", hit_k, hit_chg, TIMEOUT);
        end
        n_tests++;
        if (obs() !== pack(0, 0, 0, 0, 0, 0, 0, 14)) begin
            n_fail++; $display("FAIL timeout_idle: got %h expected %h", obs(), pack(0, 0, 0, 0, 0, 0, 0, 14));
        end
`else
        n_tests++;
        if (hit_k != 0) begin
            n_fail++; $display("FAIL timeout_none: got refund at cycle %0d expected none", hit_k);
        end
        n_tests++;
        if (obs() !== pack(1, 0, 0, 0, 0, 2, 0, 14)) begin
            n_fail++; $display("FAIL timeout_hold: got %h expected %h", obs(), pack(1, 0, 0, 0, 0, 2, 0, 14));
        end
`endif
    endtask

    task automatic test_random();
        int cv, val, btn, s;
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) do_reset();
            cv  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            val = int'($urandom_range(0, 3));
            btn = ($urandom_range(0, 3) == 0) ? 1 : 0;
            s   = int'($urandom_range(0, 3));
            step(cv, val, btn, s);
            n_tests++;
            if (obs() !== model_exp()) begin
                n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs(), model_exp());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_buy();
        test_change();
        test_same_cycle();
        test_sold_out();
        test_reject();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
